// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box/Rcon constants and GF(2^8) helpers.
// Byte 0 of every 128-bit block sits in bits [127:120], column-major.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam int NR = 10;

    // Entry i of this packed table is SBOX[i]; row 0 holds entries 00..0f.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Padded to 16 entries so a 4-bit round counter indexes it directly.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes128_encryption.sv
// Iterative AES-128 encryptor: one round per clock, key schedule expanded
// alongside the state so only the current round key is ever stored.
module aes128_encryption
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         valid,
    output logic [127:0] ciphertext
);

    typedef enum logic {S_IDLE, S_RUN} fsm_t;

    fsm_t        r_fsm, w_fsm_next;
    state_t      r_state, w_state_next;
    state_t      r_rk, w_rk_next;
    logic [3:0]  r_round, w_round_next;
    state_t      r_ct, w_ct_next;
    logic        r_valid, w_valid_next;

    byte_t       w_sb [16];
    byte_t       w_sr [16];
    byte_t       w_ks [4];
    state_t      w_sr_flat;
    state_t      w_mc_flat;
    state_t      w_rk_exp;
    word_t       w_t;

    // SubBytes on the state, then ShiftRows by pure rewiring.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_state_sbox
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;

            aes_sbox u_sbox (
                .i_byte (r_state[127-8*gi -: 8]),
                .o_byte (w_sb[gi])
            );

            assign w_sr[gi] = w_sb[SRC];
            assign w_sr_flat[127-8*gi -: 8] = w_sr[gi];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            byte_t a0, a1, a2, a3;
            assign a0 = w_sr[4*gi+0];
            assign a1 = w_sr[4*gi+1];
            assign a2 = w_sr[4*gi+2];
            assign a3 = w_sr[4*gi+3];

            assign w_mc_flat[127-32*gi -: 8] = xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
            assign w_mc_flat[119-32*gi -: 8] = a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3;
            assign w_mc_flat[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3);
            assign w_mc_flat[103-32*gi -: 8] = gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    // SubWord(RotWord(w3)): byte gi of the rotated word is byte gi+1 of w3.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
            aes_sbox u_sbox (
                .i_byte (r_rk[31-8*((gi+1)%4) -: 8]),
                .o_byte (w_ks[gi])
            );
        end
    endgenerate

    assign w_t = {w_ks[0] ^ RCON[r_round], w_ks[1], w_ks[2], w_ks[3]};

    always_comb begin
        word_t w0, w1, w2, w3;
        w0 = r_rk[127:96] ^ w_t;
        w1 = r_rk[95:64]  ^ w0;
        w2 = r_rk[63:32]  ^ w1;
        w3 = r_rk[31:0]   ^ w2;
        w_rk_exp = {w0, w1, w2, w3};
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_rk_next    = r_rk;
        w_round_next = r_round;
        w_ct_next    = r_ct;
        w_valid_next = 1'b0;

        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_state_next = plaintext ^ key;
                    w_rk_next    = key;
                    w_round_next = 4'd1;
                    w_fsm_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_rk_next = w_rk_exp;
                if (r_round == 4'(NR)) begin
                    w_ct_next    = w_sr_flat ^ w_rk_exp;
                    w_valid_next = 1'b1;
                    w_round_next = 4'd0;
                    w_fsm_next   = S_IDLE;
                end else begin
                    w_state_next = w_mc_flat ^ w_rk_exp;
                    w_round_next = r_round + 4'd1;
                end
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_rk    <= '0;
            r_round <= 4'd0;
            r_ct    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_rk    <= w_rk_next;
            r_round <= w_round_next;
            r_ct    <= w_ct_next;
            r_valid <= w_valid_next;
        end
    end

    assign busy       = (r_fsm == S_RUN);
    assign valid      = r_valid;
    assign ciphertext = r_ct;

endmodule

// File: tb/tb_aes128_encryption.sv
// Bench for aes128_encryption: a field-arithmetic AES reference plus a
// transaction-level interface model checked every cycle, and directed vectors.
module tb_aes128_encryption;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         busy;
    logic         valid;
    logic [127:0] ciphertext;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_SP  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C_SP  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_encryption dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .valid      (valid),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference AES from field arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Multiplicative inverse (x^254) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        logic [7:0]  coef [4];
        logic [127:0] out;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_ref(s[i]);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) u[4*c+j] = s[4*((c+j)%4)+j];
            if (r != 10) begin
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < 4; i++) begin
                        s[4*c+i] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[4*c+i] = s[4*c+i] ^ gmul(coef[(j-i+4)%4], u[4*c+j]);
                    end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = u[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- interface model: 10 edges from accept to result ----------------
    logic         m_init = 1'b0;
    logic         m_busy, m_valid;
    logic [127:0] m_ct, m_pending;
    int           m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_ct    <= '0;
            m_cnt   <= 0;
        end else begin
            m_valid <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy    <= 1'b1;
                    m_cnt     <= 10;
                    m_pending <= aes_ref(plaintext, key);
                end
            end else begin
                if (m_cnt == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_ct    <= m_pending;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("cyc busy", {127'h0, busy}, {127'h0, m_busy});
            chk("cyc valid", {127'h0, valid}, {127'h0, m_valid});
            chk("cyc ciphertext", ciphertext, m_ct);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_block(input string name, input logic [127:0] p,
                             input logic [127:0] k, input logic [127:0] exp);
        int lat;
        lat = 0;
        @(posedge clk); #1 start = 1'b1; plaintext = p; key = k;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
        chk({name, " latency"}, 128'(lat), 128'd10);
        chk({name, " ct"}, ciphertext, exp);
        @(posedge clk); #1;
        chk({name, " valid single"}, {127'h0, valid}, 128'h0);
        $display("block %s: pt=%h key=%h ct=%h latency=%0d", name, p, k, ciphertext, lat);
    endtask

    initial begin
        int first, second, nv, nb;

        chk("ref C.1", aes_ref(P_C1, K_C1), C_C1);
        chk("ref SP800", aes_ref(P_SP, K_SP), C_SP);
        chk("ref App.B", aes_ref(P_B, K_SP), C_B);
        chk("ref zero", aes_ref('0, '0), C_Z);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy", {127'h0, busy}, 128'h0);
        chk("reset valid", {127'h0, valid}, 128'h0);
        chk("reset ct", ciphertext, 128'h0);

        run_block("C.1", P_C1, K_C1, C_C1);
        run_block("SP800", P_SP, K_SP, C_SP);
        run_block("App.B", P_B, K_SP, C_B);
        run_block("zero", '0, '0, C_Z);

        // start held high; inputs swapped right after acceptance
        @(posedge clk); #1 start = 1'b1; plaintext = P_C1; key = K_C1;
        @(posedge clk); #1 plaintext = P_SP; key = K_SP;
        first = 0; second = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (valid && first == 0) begin
                first = n;
                chk("b2b first ct", ciphertext, C_C1);
            end else if (valid && second == 0) begin
                second = n;
                start = 1'b0;
                chk("b2b second ct", ciphertext, C_SP);
                break;
            end else if (first != 0) begin
                chk("b2b ct held", ciphertext, C_C1);
            end
        end
        start = 1'b0;
        chk("b2b first latency", 128'(first), 128'd10);
        chk("b2b spacing", 128'(second - first), 128'd11);
        $display("back-to-back: first at %0d, second at %0d, ct=%h", first, second, ciphertext);
        repeat (3) @(posedge clk);
        #1 chk("b2b ct after", ciphertext, C_SP);

        // reset while round 5 is in the register
        @(posedge clk); #1 start = 1'b1; plaintext = P_C1; key = K_C1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", {127'h0, busy}, 128'h0);
        chk("abort valid", {127'h0, valid}, 128'h0);
        chk("abort ct", ciphertext, 128'h0);
        rst = 1'b0;
        nv = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        chk("abort no valid", 128'(nv), 128'h0);
        $display("abort: reset at round 5, valid pulses afterwards=%0d", nv);
        run_block("C.1 after abort", P_C1, K_C1, C_C1);

        // idle after reset
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        nv = 0; nb = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (valid) nv++;
            if (busy) nb++;
        end
        chk("idle valid count", 128'(nv), 128'h0);
        chk("idle busy count", 128'(nb), 128'h0);
        $display("idle: 50 cycles, valid=%0d busy=%0d", nv, nb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
